param_wr_intf: RTL and testbench

- Peripheral-bus slave sitting directly upstream of the reconfigurable-logic parameter registers.
- Translates CPU word accesses on the peripheral bus into one-cycle parameter write strobes with address and data.
- Drives the read-address mux select and returns the selected read data to the CPU.
- Provides an address register with optional auto-increment, so software can burst-write or burst-read parameter tables.

---
 rtl/param_wr_intf_pkg.sv | 14 +
 rtl/param_rd_buf.sv | 29 ++
 rtl/param_wr_intf.sv | 110 +++++++++++
 tb/tb_param_wr_intf.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/param_wr_intf_pkg.sv
// Shared constants for the parameter write interface.
// Register offsets, bus write codes and address-register fields.
package param_wr_intf_pkg;

  localparam int unsigned REG_ADDR = 0;
  localparam int unsigned REG_DATA = 1;

  localparam logic [1:0] PERWR_WORD = 2'b11;
  localparam logic [1:0] PERWR_READ = 2'b00;

  localparam int unsigned AUTOINC_BIT = 15;
  localparam int unsigned ADDR_MSB    = 7;

endpackage

// File: rtl/param_rd_buf.sv
// Registered copy of the parameter read mux output.
// Only built when PARAM_WR_INTF_RDBUF_EN is defined.
`ifdef PARAM_WR_INTF_RDBUF_EN
module param_rd_buf (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic [15:0] RdData_i,
  output logic [15:0] RdBuf_o
);

  logic [15:0] rd_buf_d;
  logic [15:0] rd_buf_q;

  always_comb begin
    rd_buf_d = RdData_i;
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      rd_buf_q <= '0;
    end else begin
      rd_buf_q <= rd_buf_d;
    end
  end

  assign RdBuf_o = rd_buf_q;

endmodule
`endif

// File: rtl/param_wr_intf.sv
// Peripheral-bus slave driving parameter write strobes and read select.
// Define PARAM_WR_INTF_RDBUF_EN to register the read data path.
module param_wr_intf
  import param_wr_intf_pkg::*;
#(
  parameter logic [15:0] BaseAddr    = 16'h0188,
  parameter int unsigned WrAddrWidth = 3,
  parameter int unsigned RdAddrWidth = 1
) (
  input  logic                   Clk_i,
  input  logic                   Reset_i,
  input  logic [13:0]            PerAddr_i,
  input  logic [15:0]            PerDIn_i,
  output logic [15:0]            PerDOut_o,
  input  logic [1:0]             PerWr_i,
  input  logic                   PerEn_i,
  output logic [WrAddrWidth-1:0] ParamWrAddr_o,
  output logic [15:0]            ParamWrData_o,
  output logic                   ParamWr_o,
  output logic [RdAddrWidth-1:0] ParamRdAddr_o,
  input  logic [15:0]            ParamRdData_i
);

  localparam logic [13:0] A_WORD = BaseAddr[14:1] + 14'(REG_ADDR);
  localparam logic [13:0] D_WORD = BaseAddr[14:1] + 14'(REG_DATA);

  logic                   sel_a;
  logic                   sel_d;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [15:0]            rd_val;

  logic [7:0]             addr_d,    addr_q;
  logic                   autoinc_d, autoinc_q;
  logic [WrAddrWidth-1:0] wr_addr_d, wr_addr_q;
  logic [15:0]            wr_data_d, wr_data_q;
  logic                   wr_d,      wr_q;

  logic                   unused_din;
  assign unused_din = ^PerDIn_i[AUTOINC_BIT-1:ADDR_MSB+1];

`ifdef PARAM_WR_INTF_RDBUF_EN
  param_rd_buf u_rd_buf (
    .Clk_i    (Clk_i),
    .Reset_i  (Reset_i),
    .RdData_i (ParamRdData_i),
    .RdBuf_o  (rd_val)
  );
`else
  assign rd_val = ParamRdData_i;
`endif

  always_comb begin
    sel_a  = PerEn_i && (PerAddr_i == A_WORD);
    sel_d  = PerEn_i && (PerAddr_i == D_WORD);
    wr_acc = (PerWr_i == PERWR_WORD);
    rd_acc = (PerWr_i == PERWR_READ);
  end

  always_comb begin
    addr_d    = addr_q;
    autoinc_d = autoinc_q;
    wr_addr_d = addr_q[WrAddrWidth-1:0];
    wr_data_d = wr_data_q;
    wr_d      = 1'b0;
    PerDOut_o = '0;
    unique case (1'b1)
      sel_a && wr_acc: begin
        addr_d    = PerDIn_i[ADDR_MSB:0];
        autoinc_d = PerDIn_i[AUTOINC_BIT];
      end
      sel_a && rd_acc: begin
        PerDOut_o = {autoinc_q, 7'b0, addr_q};
      end
      sel_d && wr_acc: begin
        wr_data_d = PerDIn_i;
        wr_d      = 1'b1;
        if (autoinc_q) addr_d = addr_q + 8'd1;
      end
      sel_d && rd_acc: begin
        PerDOut_o = rd_val;
        if (autoinc_q) addr_d = addr_q + 8'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      addr_q    <= '0;
      autoinc_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_q      <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      autoinc_q <= autoinc_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_q      <= wr_d;
    end
  end

  assign ParamWrAddr_o = wr_addr_q;
  assign ParamWrData_o = wr_data_q;
  assign ParamWr_o     = wr_q;
  assign ParamRdAddr_o = addr_q[RdAddrWidth-1:0];

endmodule

// File: tb/tb_param_wr_intf.sv
// Directed bench for param_wr_intf (default combinational read path).
// Vector table plus hand-written reset corner sequences.
module tb_param_wr_intf;

  localparam logic [13:0] A_W = 14'h0C4;
  localparam logic [13:0] D_W = 14'h0C5;
  localparam logic [13:0] F_W = 14'h0C6;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic [1:0]  per_wr;
  logic        per_en;
  logic [2:0]  p_waddr;
  logic [15:0] p_wdata;
  logic        p_wr;
  logic [0:0]  p_raddr;
  logic [15:0] p_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_comb p_rdata = p_raddr[0] ? 16'h1234 : 16'h5678;

  param_wr_intf dut (
    .Clk_i         (clk),
    .Reset_i       (rst),
    .PerAddr_i     (per_addr),
    .PerDIn_i      (per_din),
    .PerDOut_o     (per_dout),
    .PerWr_i       (per_wr),
    .PerEn_i       (per_en),
    .ParamWrAddr_o (p_waddr),
    .ParamWrData_o (p_wdata),
    .ParamWr_o     (p_wr),
    .ParamRdAddr_o (p_raddr),
    .ParamRdData_i (p_rdata)
  );

  typedef struct packed {
    logic        en;
    logic [13:0] addr;
    logic [1:0]  wr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        pwr;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        raddr;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [13:0] a,
                       input logic [1:0] w, input logic [15:0] d);
    per_en   = en;
    per_addr = a;
    per_wr   = w;
    per_din  = d;
  endtask

  task automatic idle();
    drive(1'b0, 14'h0, 2'b00, 16'h0);
  endtask

  initial begin
    vecs[0]  = '{1, A_W, 2'b00, 16'h0000, 16'h0000, 0, 3'd0, 16'h0000, 0};
    vecs[1]  = '{1, A_W, 2'b11, 16'h0004, 16'h0000, 0, 3'd0, 16'h0000, 0};
    vecs[2]  = '{1, D_W, 2'b11, 16'hBEEF, 16'h0000, 1, 3'd4, 16'hBEEF, 0};
    vecs[3]  = '{0, D_W, 2'b00, 16'h0000, 16'h0000, 0, 3'd4, 16'hBEEF, 0};
    vecs[4]  = '{1, A_W, 2'b00, 16'h0000, 16'h0004, 0, 3'd4, 16'hBEEF, 0};
    vecs[5]  = '{1, A_W, 2'b11, 16'h8005, 16'h0000, 0, 3'd4, 16'hBEEF, 1};
    vecs[6]  = '{1, D_W, 2'b11, 16'h0011, 16'h0000, 1, 3'd5, 16'h0011, 0};
    vecs[7]  = '{1, D_W, 2'b11, 16'h0022, 16'h0000, 1, 3'd6, 16'h0022, 1};
    vecs[8]  = '{1, D_W, 2'b11, 16'h0033, 16'h0000, 1, 3'd7, 16'h0033, 0};
    vecs[9]  = '{1, A_W, 2'b00, 16'h0000, 16'h8008, 0, 3'd0, 16'h0033, 0};
    vecs[10] = '{1, A_W, 2'b11, 16'h8001, 16'h0000, 0, 3'd0, 16'h0033, 1};
    vecs[11] = '{1, D_W, 2'b00, 16'h0000, 16'h1234, 0, 3'd1, 16'h0033, 0};
    vecs[12] = '{1, D_W, 2'b00, 16'h0000, 16'h5678, 0, 3'd2, 16'h0033, 1};
    vecs[13] = '{1, D_W, 2'b01, 16'hFFFF, 16'h0000, 0, 3'd3, 16'h0033, 1};
    vecs[14] = '{1, F_W, 2'b11, 16'hFFFF, 16'h0000, 0, 3'd3, 16'h0033, 1};
    vecs[15] = '{1, A_W, 2'b00, 16'h0000, 16'h8003, 0, 3'd3, 16'h0033, 1};
    vecs[16] = '{1, F_W, 2'b00, 16'h0000, 16'h0000, 0, 3'd3, 16'h0033, 1};
    vecs[17] = '{0, A_W, 2'b00, 16'h0000, 16'h0000, 0, 3'd3, 16'h0033, 1};

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr", 0, {15'b0, p_wr}, 16'h0);
    chk("rst_wdata", 0, p_wdata, 16'h0);
    chk("rst_dout", 0, per_dout, 16'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].addr, vecs[i].wr, vecs[i].din);
      #2;
      chk("dout", i, per_dout, vecs[i].dout);
      @(posedge clk);
      #1;
      chk("pwr", i, {15'b0, p_wr}, {15'b0, vecs[i].pwr});
      chk("waddr", i, {13'b0, p_waddr}, {13'b0, vecs[i].waddr});
      chk("wdata", i, p_wdata, vecs[i].wdata);
      chk("raddr", i, {15'b0, p_raddr}, {15'b0, vecs[i].raddr});
    end

    // Strobe at address 3 with auto-increment on, then reset mid-strobe.
    drive(1'b1, D_W, 2'b11, 16'h4444);
    @(posedge clk);
    #1;
    chk("mid_wr", 0, {15'b0, p_wr}, 16'h1);
    chk("mid_waddr", 0, {13'b0, p_waddr}, 16'h3);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_wr", 1, {15'b0, p_wr}, 16'h0);
    chk("mid_wdata", 1, p_wdata, 16'h0);
    @(posedge clk);
    #1;
    chk("mid_wr", 2, {15'b0, p_wr}, 16'h0);
    drive(1'b1, A_W, 2'b00, 16'h0);
    #2;
    chk("mid_addr", 0, per_dout, 16'h0000);
    @(posedge clk);
    #1;

    // Reset must win over a same-cycle address and data write.
    drive(1'b1, A_W, 2'b11, 16'h8077);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, D_W, 2'b11, 16'h5555);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("dom_wr", 0, {15'b0, p_wr}, 16'h0);
    chk("dom_wdata", 0, p_wdata, 16'h0);
    drive(1'b1, A_W, 2'b00, 16'h0);
    #2;
    chk("dom_addr", 0, per_dout, 16'h0000);
    @(posedge clk);
    #1;
    idle();
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
